multichannel_accumulator: RTL and testbench

MULTICHANNEL_ACCUMULATOR -- requirements
Module: multichannel_accumulator

---
 rtl/multichannel_accumulator_pkg.sv | 51 +++++
 rtl/multichannel_accumulator_lane.sv | 53 +++++
 rtl/multichannel_accumulator.sv | 99 +++++++++
 tb/tb_multichannel_accumulator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multichannel_accumulator_pkg.sv
// Shared types and arithmetic for the multichannel accumulator.
// sat_add works on 64-bit sign-extended operands so one function serves any
// accumulator width up to 64 bits.
package multichannel_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int MaxWidth = 64;

  typedef struct packed {
    logic [MaxWidth-1:0] sum;
    logic                ovf;
  } add_res_t;

  // Signed add of two values that are valid in 'width' bits; flags overflow
  // of a width-bit result and either clamps or wraps it.
  function automatic add_res_t sat_add(input logic [MaxWidth-1:0] a,
                                       input logic [MaxWidth-1:0] b,
                                       input int                  width,
                                       input logic                saturate);
    logic [MaxWidth:0]   full;
    logic [MaxWidth-1:0] wrapped;
    logic [MaxWidth-1:0] max_v;
    logic [MaxWidth-1:0] min_v;
    logic                top;
    add_res_t            res;
    full = {a[MaxWidth-1], a} + {b[MaxWidth-1], b};
    top  = 1'b0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (i == width - 1) top = full[i];
    end
    for (int i = 0; i < MaxWidth; i++) begin
      wrapped[i] = (i < width) ? full[i] : top;
      max_v[i]   = (i < width - 1);
      min_v[i]   = (i >= width - 1);
    end
    res.ovf = (wrapped != full[MaxWidth-1:0]) || (full[MaxWidth] != full[MaxWidth-1]);
    if (res.ovf && saturate) begin
      // full[MaxWidth] is the true sign of the unbounded sum.
      res.sum = full[MaxWidth] ? min_v : max_v;
    end else begin
      res.sum = wrapped;
    end
    return res;
  endfunction

endpackage

// File: rtl/multichannel_accumulator_lane.sv
// One accumulator lane: holds the running sum and its sticky overflow flag.
// The top-level FSM decides when the lane loads, adds or clears.
module acc_lane
  import multichannel_accumulator_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int AccWidth  = 32,
  parameter bit Saturate  = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_ni,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic                 add_i,
  input  logic [DataWidth-1:0] op_i,
  output logic [AccWidth-1:0]  acc_o,
  output logic                 ovf_o
);

  logic [AccWidth-1:0] r_acc;
  logic                r_ovf;
  logic [MaxWidth-1:0] w_acc_ext;
  logic [MaxWidth-1:0] w_op_ext;
  add_res_t            w_res;
  logic                w_unused_bits;

  assign w_acc_ext     = MaxWidth'($signed(r_acc));
  assign w_op_ext      = MaxWidth'($signed(op_i));
  assign w_res         = sat_add(w_acc_ext, w_op_ext, AccWidth, Saturate);
  // Only the low AccWidth bits of the sum are kept.
  assign w_unused_bits = ^w_res.sum;

  // Accumulator and sticky overflow: clear wins, then load, then add.
  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (clear_i) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (load_i) begin
      r_acc <= AccWidth'($signed(op_i));
      r_ovf <= 1'b0;
    end else if (add_i) begin
      r_acc <= w_res.sum[AccWidth-1:0];
      r_ovf <= r_ovf | w_res.ovf;
    end
  end

  assign acc_o = r_acc;
  assign ovf_o = r_ovf;

endmodule

// File: rtl/multichannel_accumulator.sv
// Multichannel accumulator: NumChannels signed lanes summed over a window of
// beats closed by last_i; the result is held until the consumer takes it.
// Handshake: a beat transfers when in_valid_i && in_ready_o (in_ready_o is
// high in IDLE/ACCUM); a result transfers when out_valid_o && out_ready_i
// (out_valid_o is high only in HOLD). clear_i overrides both.
module multichannel_accumulator
  import multichannel_accumulator_pkg::*;
#(
  parameter int DataWidth   = 8,
  parameter int AccWidth    = 32,
  parameter int NumChannels = 4,
  parameter int Saturate    = 1,
  parameter int CountWidth  = 16
) (
  input  logic                                  clock,
  input  logic                                  reset_ni,
  input  logic                                  clear_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [NumChannels-1:0][DataWidth-1:0] op_i,
  input  logic                                  last_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [NumChannels-1:0][AccWidth-1:0]  acc_o,
  output logic [NumChannels-1:0]                overflow_o,
  output logic [CountWidth-1:0]                 beat_count_o,
  output state_e                                state_o
);

  state_e                r_state;
  state_e                w_next_state;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_add;
  logic [CountWidth-1:0] r_count;

  // State register.
  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) r_state <= ST_IDLE;
    else           r_state <= w_next_state;
  end

  // Next-state logic; clear forces IDLE regardless of beats or handshakes.
  always_comb begin
    w_next_state = r_state;
    if (clear_i) begin
      w_next_state = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_ACCUM: if (in_valid_i) w_next_state = last_i ? ST_HOLD : ST_ACCUM;
        ST_HOLD:           if (out_ready_i) w_next_state = ST_IDLE;
        default:           w_next_state = ST_IDLE;
      endcase
    end
  end

  // Output decode: handshake flags and the lane load/add strobes.
  always_comb begin
    in_ready_o  = (r_state != ST_HOLD);
    out_valid_o = (r_state == ST_HOLD);
    w_accept    = in_valid_i && (r_state != ST_HOLD) && !clear_i;
    w_load      = w_accept && (r_state == ST_IDLE);
    w_add       = w_accept && (r_state == ST_ACCUM);
  end

  // Beat counter, saturating at all-ones.
  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= CountWidth'(1);
    end else if (w_add && (r_count != '1)) begin
      r_count <= r_count + CountWidth'(1);
    end
  end

  assign beat_count_o = r_count;
  assign state_o      = r_state;

  for (genvar g = 0; g < NumChannels; g++) begin : g_lane
    acc_lane #(
      .DataWidth(DataWidth),
      .AccWidth (AccWidth),
      .Saturate (Saturate != 0)
    ) u_lane (
      .clock   (clock),
      .reset_ni(reset_ni),
      .clear_i (clear_i),
      .load_i  (w_load),
      .add_i   (w_add),
      .op_i    (op_i[g]),
      .acc_o   (acc_o[g]),
      .ovf_o   (overflow_o[g])
    );
  end

endmodule

// File: tb/tb_multichannel_accumulator.sv
// Bench for multichannel_accumulator: a wide 4-lane instance plus two narrow
// 2-lane instances (8-bit accumulators, clamping and wrapping) sharing the
// same control and lane 0/1 operands, all checked against one window model.
module tb_multichannel_accumulator;
  import multichannel_accumulator_pkg::*;

  logic clock = 1'b0;
  logic reset_ni = 1'b0;
  logic clear, in_valid, last, out_ready;
  logic [3:0][7:0] op;

  logic            in_ready, out_valid;
  logic [3:0][31:0] acc;
  logic [3:0]      ovf;
  logic [15:0]     cnt;
  state_e          st;

  logic            rdy_s, vld_s, rdy_w, vld_w;
  logic [1:0][7:0] acc_s, acc_w;
  logic [1:0]      ovf_s, ovf_w;
  logic [15:0]     cnt_s, cnt_w;
  state_e          st_s, st_w;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the window in plain integers.
  state_e   m_st;
  longint   m_acc[4];
  bit [3:0] m_ovf;
  longint   s_acc[2], w_acc[2];
  bit [1:0] s_ovf, w_ovf;
  longint   m_cnt;

  multichannel_accumulator dut (
    .clock(clock), .reset_ni(reset_ni), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .op_i(op), .last_i(last), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .acc_o(acc), .overflow_o(ovf), .beat_count_o(cnt),
    .state_o(st)
  );

  multichannel_accumulator #(.DataWidth(8), .AccWidth(8), .NumChannels(2), .Saturate(1)) dut_sat (
    .clock(clock), .reset_ni(reset_ni), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(rdy_s), .op_i(op[1:0]), .last_i(last), .out_valid_o(vld_s),
    .out_ready_i(out_ready), .acc_o(acc_s), .overflow_o(ovf_s), .beat_count_o(cnt_s),
    .state_o(st_s)
  );

  multichannel_accumulator #(.DataWidth(8), .AccWidth(8), .NumChannels(2), .Saturate(0)) dut_wrap (
    .clock(clock), .reset_ni(reset_ni), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(rdy_w), .op_i(op[1:0]), .last_i(last), .out_valid_o(vld_w),
    .out_ready_i(out_ready), .acc_o(acc_w), .overflow_o(ovf_w), .beat_count_o(cnt_w),
    .state_o(st_w)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] b8(input int v);
    return 8'(v);
  endfunction

  // Signed add in w bits: returns the clamped or wrapped sum, flags overflow.
  function automatic longint add_model(input longint a, input longint b, input int w,
                                       input bit sat, output bit ov);
    longint mx, mn, s;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    s  = a + b;
    ov = (s > mx) || (s < mn);
    if (!ov) return s;
    if (sat) return (s > mx) ? mx : mn;
    return (s > mx) ? s - (mx - mn + 1) : s + (mx - mn + 1);
  endfunction

  function automatic void model_reset();
    m_st = ST_IDLE;
    m_cnt = 0;
    m_ovf = '0; s_ovf = '0; w_ovf = '0;
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
    for (int i = 0; i < 2; i++) begin s_acc[i] = 0; w_acc[i] = 0; end
  endfunction

  always @(negedge reset_ni) model_reset();

  // Model step: the window rules applied to the inputs seen at each edge.
  always @(posedge clock) begin
    bit ov;
    if (reset_ni) begin
      if (clear) begin
        model_reset();
      end else if (in_valid && m_st != ST_HOLD) begin
        if (m_st == ST_IDLE) begin
          for (int i = 0; i < 4; i++) m_acc[i] = longint'($signed(op[i]));
          for (int i = 0; i < 2; i++) begin
            s_acc[i] = longint'($signed(op[i]));
            w_acc[i] = longint'($signed(op[i]));
          end
          m_ovf = '0; s_ovf = '0; w_ovf = '0;
          m_cnt = 1;
        end else begin
          for (int i = 0; i < 4; i++) begin
            m_acc[i] = add_model(m_acc[i], longint'($signed(op[i])), 32, 1'b1, ov);
            if (ov) m_ovf[i] = 1'b1;
          end
          for (int i = 0; i < 2; i++) begin
            s_acc[i] = add_model(s_acc[i], longint'($signed(op[i])), 8, 1'b1, ov);
            if (ov) s_ovf[i] = 1'b1;
            w_acc[i] = add_model(w_acc[i], longint'($signed(op[i])), 8, 1'b0, ov);
            if (ov) w_ovf[i] = 1'b1;
          end
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        m_st = last ? ST_HOLD : ST_ACCUM;
      end else if (m_st == ST_HOLD && out_ready) begin
        m_st = ST_IDLE;
      end
    end
  end

  // Scoreboard compare on every falling edge.
  always @(negedge clock) begin
    chk("state", longint'(st), longint'(m_st));
    chk("in_ready", longint'(in_ready), longint'(m_st != ST_HOLD));
    chk("out_valid", longint'(out_valid), longint'(m_st == ST_HOLD));
    chk("beat_count", longint'(cnt), m_cnt);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("acc[%0d]", i), longint'($signed(acc[i])), m_acc[i]);
      chk($sformatf("ovf[%0d]", i), longint'(ovf[i]), longint'(m_ovf[i]));
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("sat_acc[%0d]", i), longint'($signed(acc_s[i])), s_acc[i]);
      chk($sformatf("sat_ovf[%0d]", i), longint'(ovf_s[i]), longint'(s_ovf[i]));
      chk($sformatf("wrap_acc[%0d]", i), longint'($signed(acc_w[i])), w_acc[i]);
      chk($sformatf("wrap_ovf[%0d]", i), longint'(ovf_w[i]), longint'(w_ovf[i]));
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input int o0, input int o1, input int o2, input int o3, input logic l);
    in_valid = 1'b1;
    op = {b8(o3), b8(o2), b8(o1), b8(o0)};
    last = l;
    step();
    in_valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    model_reset();
    clear = 1'b0; in_valid = 1'b0; last = 1'b0; out_ready = 1'b0; op = '0;
    repeat (2) @(posedge clock);
    #3 reset_ni = 1'b1;
    step();
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset in_ready", longint'(in_ready), 1);
    chk("reset beat_count", longint'(cnt), 0);
    chk("reset acc0", longint'($signed(acc[0])), 0);

    // Three-beat window 5, -2, 7
    beat(5, 0, 0, 0, 1'b0);
    beat(-2, 0, 0, 0, 1'b0);
    beat(7, 0, 0, 0, 1'b1);
    chk("win3 out_valid", longint'(out_valid), 1);
    chk("win3 acc0", longint'($signed(acc[0])), 10);
    chk("win3 beat_count", longint'(cnt), 3);
    chk("win3 overflow", longint'(ovf), 0);
    release_result();
    chk("win3 released", longint'(out_valid), 0);

    // 100 + 100 in 8-bit lanes: clamp to 127 or wrap to -56
    beat(100, 0, 0, 0, 1'b0);
    beat(100, 0, 0, 0, 1'b1);
    chk("sat acc0", longint'($signed(acc_s[0])), 127);
    chk("sat ovf0", longint'(ovf_s[0]), 1);
    chk("wrap acc0", longint'($signed(acc_w[0])), -56);
    chk("wrap ovf0", longint'(ovf_w[0]), 1);
    chk("wide acc0", longint'($signed(acc[0])), 200);

    // Back-pressure in HOLD with beats offered
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      op = {b8($urandom_range(0, 255)), b8($urandom_range(0, 255)),
            b8($urandom_range(0, 255)), b8($urandom_range(0, 255))};
      step();
      chk("hold in_ready", longint'(in_ready), 0);
      chk("hold out_valid", longint'(out_valid), 1);
      chk("hold acc0", longint'($signed(acc[0])), 200);
      chk("hold beat_count", longint'(cnt), 2);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("hold exit state", longint'(st), longint'(ST_IDLE));
    chk("hold exit no beat", longint'(cnt), 2);

    // Four lanes, four beats
    for (int k = 0; k < 4; k++) beat(1, -1, 127, -128, k == 3);
    chk("lanes acc0", longint'($signed(acc[0])), 4);
    chk("lanes acc1", longint'($signed(acc[1])), -4);
    chk("lanes acc2", longint'($signed(acc[2])), 508);
    chk("lanes acc3", longint'($signed(acc[3])), -512);
    chk("lanes overflow", longint'(ovf), 0);
    release_result();

    // Clear together with a last beat
    beat(9, 9, 9, 9, 1'b0);
    clear = 1'b1;
    beat(3, 3, 3, 3, 1'b1);
    clear = 1'b0;
    chk("clear state", longint'(st), longint'(ST_IDLE));
    chk("clear out_valid", longint'(out_valid), 0);
    chk("clear beat_count", longint'(cnt), 0);
    chk("clear acc0", longint'($signed(acc[0])), 0);
    step();
    chk("clear no hold", longint'(out_valid), 0);

    // Asynchronous reset mid-window
    beat(4, 4, 4, 4, 1'b0);
    beat(5, 5, 5, 5, 1'b0);
    #1 reset_ni = 1'b0;
    #1;
    chk("async beat_count", longint'(cnt), 0);
    chk("async acc0", longint'($signed(acc[0])), 0);
    chk("async in_ready", longint'(in_ready), 1);
    #1 reset_ni = 1'b1;
    beat(3, 0, 0, 0, 1'b0);
    chk("post reset acc0", longint'($signed(acc[0])), 3);
    chk("post reset beat_count", longint'(cnt), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      last      = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      op = {b8($urandom_range(0, 255)), b8($urandom_range(0, 255)),
            b8($urandom_range(0, 255)), b8($urandom_range(0, 255))};
      step();
    end
    in_valid = 1'b0; last = 1'b0; out_ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;

    // Beat counter saturation
    in_valid = 1'b1;
    for (int k = 0; k < 65540; k++) begin
      op = {b8($urandom_range(0, 2) - 1), b8($urandom_range(0, 2) - 1),
            b8($urandom_range(0, 2) - 1), b8($urandom_range(0, 2) - 1)};
      step();
    end
    in_valid = 1'b0;
    chk("count saturates", longint'(cnt), 65535);
    beat(1, 1, 1, 1, 1'b1);
    chk("count stays saturated", longint'(cnt), 65535);
    release_result();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
